// File: rtl/multi_port_arbiter_pkg.sv
// Shared types for the multi-port cacheline arbiter.
//   state_t     : arbiter FSM state (IDLE waits for a request, BUSY owns the
//                 downstream port until mem_resp_i).
//   offset_bits : number of byte-offset address bits inside one cacheline;
//                 these bits are forced to zero on the downstream address.
package arbiter_types;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int offset_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

endpackage

// File: rtl/multi_port_arbiter_if.sv
// Bus bundle between the upstream requesters, the arbiter and the shared L2.
//   port_read_i/port_write_i : per-port request level, held until the port's resp
//   port_address_i           : per-port line address
//   port_wdata_i             : per-port write line
//   port_resp_o              : per-port one-cycle completion
//   port_rdata_o             : read line, meaningful only with the owner's resp
//   mem_read_o/mem_write_o   : downstream request level, held until mem_resp_i
//   mem_address_o            : line-aligned downstream address
//   mem_wdata_o              : downstream write line
//   mem_resp_i               : downstream one-cycle completion
//   mem_rdata_i              : downstream read line
//
// Handshake: a request (read/write) is a level that stays high until the
// matching one-cycle resp; a transfer completes in exactly the cycle the resp
// is high, and the requester must drop its level the cycle after. There is no
// separate ready; the resp pulse is the only acknowledgement.
//
// Modport slave is the arbiter; modport master is the environment around it
// (requesters plus the downstream memory).
interface multi_port_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);

  logic [NUM_PORTS-1:0]                 port_read_i;
  logic [NUM_PORTS-1:0]                 port_write_i;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] port_address_i;
  logic [NUM_PORTS-1:0][LINE_WIDTH-1:0] port_wdata_i;
  logic [NUM_PORTS-1:0]                 port_resp_o;
  logic [LINE_WIDTH-1:0]                port_rdata_o;
  logic                                 mem_read_o;
  logic                                 mem_write_o;
  logic [ADDR_WIDTH-1:0]                mem_address_o;
  logic [LINE_WIDTH-1:0]                mem_wdata_o;
  logic                                 mem_resp_i;
  logic [LINE_WIDTH-1:0]                mem_rdata_i;

  modport slave (
    input  port_read_i, port_write_i, port_address_i, port_wdata_i,
    input  mem_resp_i, mem_rdata_i,
    output port_resp_o, port_rdata_o,
    output mem_read_o, mem_write_o, mem_address_o, mem_wdata_o
  );

  modport master (
    output port_read_i, port_write_i, port_address_i, port_wdata_i,
    output mem_resp_i, mem_rdata_i,
    input  port_resp_o, port_rdata_o,
    input  mem_read_o, mem_write_o, mem_address_o, mem_wdata_o
  );

endinterface

// File: rtl/multi_port_arbiter_rr_picker.sv
// Combinational rotating-priority encoder.
//   req     : request vector, one bit per port
//   start   : first index searched when rr_mode=1 (search wraps modulo N)
//   rr_mode : 1 = rotate from start, 0 = fixed priority from index 0
//   grant   : one-hot winner (all zero when nothing requests)
//   idx     : binary winner index (0 when nothing requests)
module rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  input  logic                 rr_mode,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);

  localparam int PW = $clog2(N);

  always_comb begin
    int   base;
    int   cand;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    base  = rr_mode ? int'(start) : 0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      // start is always < N, so one subtraction is enough to wrap.
      cand = base + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/multi_port_arbiter.sv
// N-port cacheline arbiter in front of a single downstream (L2) port.
// One upstream transaction is granted at a time, its operation, line-aligned
// address and write line are latched, and the downstream request is held
// until mem_resp_i, which is routed straight back to the owner's resp bit.
//   clk, reset_n  : clock, synchronous active-low reset
//   bus           : request/response bundle (slave modport)
//   debug_state   : current FSM state
//   debug_rr_ptr  : round-robin search start pointer
module multi_port_arbiter
  import arbiter_types::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter bit RR_MODE    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  multi_port_arbiter_if.slave          bus,
  output state_t                       debug_state,
  output logic [$clog2(NUM_PORTS)-1:0] debug_rr_ptr
);

  localparam int PW     = $clog2(NUM_PORTS);
  localparam int OFFSET = offset_bits(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET){1'b1}}, {OFFSET{1'b0}}};

  state_t                state;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         win_idx;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  win_grant;
  logic [NUM_PORTS-1:0]  owner_grant;
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] win_addr;

  assign req = bus.port_read_i | bus.port_write_i;

  rr_picker #(.N(NUM_PORTS)) u_picker (
    .req     (req),
    .start   (rr_ptr),
    .rr_mode (RR_MODE),
    .grant   (win_grant),
    .idx     (win_idx)
  );

  assign win_addr = bus.port_address_i[win_idx] & LINE_MASK;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner_grant <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state       <= BUSY;
            owner_grant <= win_grant;
            // A port raising both read and write is served as a write.
            mem_write_q <= bus.port_write_i[win_idx];
            mem_read_q  <= ~bus.port_write_i[win_idx];
            addr_q      <= win_addr;
            wdata_q     <= bus.port_wdata_i[win_idx];
            rr_ptr      <= (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
          end
        end
        BUSY: begin
          // Upstream inputs are not looked at here; only the downstream resp.
          if (bus.mem_resp_i) begin
            state       <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_read_o    = mem_read_q;
  assign bus.mem_write_o   = mem_write_q;
  assign bus.mem_address_o = addr_q;
  assign bus.mem_wdata_o   = wdata_q;
  // Completion is combinational so the owner sees it in the resp cycle; a
  // resp arriving while IDLE has no owner and is dropped.
  assign bus.port_resp_o   = (state == BUSY && bus.mem_resp_i) ? owner_grant : '0;
  assign bus.port_rdata_o  = bus.mem_rdata_i;

  assign debug_state  = state;
  assign debug_rr_ptr = rr_ptr;

endmodule

// File: doc/multi_port_arbiter.md
# multi_port_arbiter

Parametrised N-port cacheline arbiter between the L1 caches (and any future requesters such as a prefetcher or victim buffer) and the shared L2 cache. One upstream transaction is granted at a time and forwarded to the single downstream port, held until the downstream response arrives, and the response is routed back to the owner. Grant order is selectable between fixed priority and round-robin. Downstream addresses are line-aligned.

## Interface
- NUM_PORTS, 2, number of upstream requesters (≥2); port 0 is the highest fixed priority
- ADDR_WIDTH, 32, address width
- LINE_WIDTH, 256, cacheline data width in bits (power of 2, ≥64)
- RR_MODE, 1, 1 selects round-robin grant; 0 selects fixed priority
- clk  in  1  clock; one clock domain
- reset_n  in  1  synchronous, active-low reset
- port_read_i  in  NUM_PORTS  per-port line read request
- port_write_i  in  NUM_PORTS  per-port line write request
- port_address_i  in  NUM_PORTS×ADDR_WIDTH  per-port address
- port_wdata_i  in  NUM_PORTS×LINE_WIDTH  per-port write line
- port_resp_o  out  NUM_PORTS  per-port one-cycle completion
- port_rdata_o  out  LINE_WIDTH  read line, shared by all ports, valid only with the owner's resp
- mem_read_o  out  1  downstream read
- mem_write_o  out  1  downstream write
- mem_address_o  out  ADDR_WIDTH  downstream address, low log2(LINE_WIDTH/8) bits forced to 0
- mem_wdata_o  out  LINE_WIDTH  downstream write line
- mem_resp_i  in  1  downstream completion
- mem_rdata_i  in  LINE_WIDTH  downstream read line

## Operation
- FSM states: IDLE, BUSY.
- IDLE: a port is requesting if its read or write is high. If no port requests, stay in IDLE. Otherwise pick a winner, latch its index, operation, aligned address and wdata, and go to BUSY.
- Read and write both high on one port: treated as a write.
- Fixed priority: the lowest requesting index wins.
- Round-robin: search starts at pointer rr_ptr and wraps modulo NUM_PORTS. On each grant to port k, rr_ptr becomes (k+1) mod NUM_PORTS, wrapping from NUM_PORTS-1 to 0.
- BUSY:
  - mem_read_o or mem_write_o is driven from the latched operation.
  - mem_address_o and mem_wdata_o are driven from the latched values, so they are stable even if upstream inputs change.
  - Upstream changes during BUSY are ignored.
  - On mem_resp_i: port_resp_o[owner]=1 in the same cycle; all other resp bits stay 0. Then go to IDLE.
- port_rdata_o = mem_rdata_i at all times (pass-through).
- A requester drops its request in the cycle after its resp. A request still held in the IDLE cycle after resp is treated as a new transaction.
- Reset, including mid-BUSY: state←IDLE, rr_ptr←0, latched registers←0. The pending transaction is dropped with no resp. A mem_resp_i arriving in IDLE is ignored.

## Timing
- Reset values: all port_resp_o=0, mem_read_o=0, mem_write_o=0, mem_address_o=0, mem_wdata_o=0.
- Request visible in IDLE at cycle t: mem_read_o/mem_write_o is high from cycle t+1, driven from a registered state.
- mem_resp_i at cycle r: port_resp_o at r (combinational), mem_read_o/mem_write_o low at r+1.
- The next grant is evaluated at r+1, so there is at least one idle cycle between downstream transactions.
- Arbiter overhead is 1 cycle before and 1 cycle after each transaction.
- Round-robin: every requester holding its request continuously is granted within NUM_PORTS transactions.

## Structure
- Package arbiter_types holds the state enum (IDLE, BUSY) and the offset-width function clog2(LINE_WIDTH/8).
- Sub-module rr_picker is a combinational rotating-priority encoder. Inputs: request vector, start pointer, mode. Outputs: one-hot grant and winner index. The arbiter instantiates it once.

## Test plan
- NUM_PORTS=2, fixed priority, both ports read at cycle 0 (0x100, 0x200) → port 0 granted first with mem_address_o=0x100 at cycle 1; port 1 granted second with 0x200, starting at the cycle after port 0's resp +1.
- RR_MODE=1, NUM_PORTS=4, all four ports hold requests continuously → grants in order 0,1,2,3,0.
- Port 1 writes to 0x1234_567F with wdata=0xA5..A5 → mem_address_o=0x1234_5660, mem_write_o=1, mem_wdata_o=0xA5..A5. Change port_wdata_i mid-BUSY → mem_wdata_o unchanged.
- Downstream resp delayed 7 cycles with mem_rdata_i=0xDEAD.. → port_resp_o[owner] pulses exactly 1 cycle in the resp cycle with rdata 0xDEAD..; the other resp bits stay 0.
- reset_n=0 during BUSY → next cycle mem_read_o=0, no port_resp_o pulse, rr_ptr=0. A following mem_resp_i in IDLE is ignored.
- read and write both high on port 0 → a single downstream write and no read.
